// File: rtl/ime_best_costx16_pkg.sv
// Shared constants for the IME large-partition cost path: partition cost widths, counts,
// MB partition mode codes and the end-of-window mode pick.
package ime_best_costx16_pkg;

  localparam int SAD8X16_LEN  = 15;
  localparam int SAD16X16_LEN = SAD8X16_LEN + 1;
  localparam int SAD8X16_NUM  = 2;
  localparam int SAD16X8_NUM  = 2;
  localparam int MV_LEN       = 7;

  localparam logic [1:0] MB_PART_16X16 = 2'd0;
  localparam logic [1:0] MB_PART_16X8  = 2'd1;
  localparam logic [1:0] MB_PART_8X16  = 2'd2;

  // Ties resolve toward the larger partition: 16x16 over 16x8 over 8x16.
  function automatic logic [1:0] pick_mb_part(input logic [SAD16X16_LEN-1:0] c16,
                                              input logic [SAD16X16_LEN-1:0] s168,
                                              input logic [SAD16X16_LEN-1:0] s816);
    logic [1:0] part;
    if (c16 <= s168 && c16 <= s816) part = MB_PART_16X16;
    else if (s168 <= s816)          part = MB_PART_16X8;
    else                            part = MB_PART_8X16;
    return part;
  endfunction

endpackage

// File: rtl/ime_best_costx16_if.sv
// Candidate-in / best-out bundle between the IME cost stage and the best-cost tracker.
// Handshake: cost_v_i qualifies one candidate per cycle with no back-pressure; last_i counts
// only together with cost_v_i; done_o is a one-cycle pulse after which results hold until start_i.
interface ime_best_costx16_if #(
  parameter int L8  = ime_best_costx16_pkg::SAD8X16_LEN,
  parameter int L16 = ime_best_costx16_pkg::SAD16X16_LEN,
  parameter int MVL = ime_best_costx16_pkg::MV_LEN
);
  logic              start_i;
  logic              cost_v_i;
  logic              last_i;
  logic [MVL-1:0]    mv_x_i;
  logic [MVL-1:0]    mv_y_i;
  logic [2*L8-1:0]   cost8x16_i;
  logic [2*L8-1:0]   cost16x8_i;
  logic [L16-1:0]    cost16x16_i;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        mb_part_o;
  logic [2*L8-1:0]   bcost8x16_o;
  logic [2*L8-1:0]   bcost16x8_o;
  logic [L16-1:0]    bcost16x16_o;
  logic [4*MVL-1:0]  bmv8x16_o;
  logic [4*MVL-1:0]  bmv16x8_o;
  logic [2*MVL-1:0]  bmv16x16_o;
  logic [1:0]        dbg_state_o;

  modport slave (
    input  start_i, cost_v_i, last_i, mv_x_i, mv_y_i, cost8x16_i, cost16x8_i, cost16x16_i,
    output busy_o, done_o, mb_part_o, bcost8x16_o, bcost16x8_o, bcost16x16_o,
           bmv8x16_o, bmv16x8_o, bmv16x16_o, dbg_state_o
  );

  modport master (
    output start_i, cost_v_i, last_i, mv_x_i, mv_y_i, cost8x16_i, cost16x8_i, cost16x16_i,
    input  busy_o, done_o, mb_part_o, bcost8x16_o, bcost16x8_o, bcost16x16_o,
           bmv8x16_o, bmv16x8_o, bmv16x16_o, dbg_state_o
  );

endinterface

// File: rtl/ime_min_tracker.sv
// Running minimum of one partition cost with its MV; clear reloads all-ones so a candidate
// arriving on the clear cycle is still judged as the first of the window.
module ime_min_tracker #(
  parameter int W   = 15,
  parameter int MVL = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [W-1:0]     cost_i,
  input  logic [2*MVL-1:0] mv_i,
  output logic [W-1:0]     best_cost_o,
  output logic [2*MVL-1:0] best_mv_o
);

  logic [W-1:0]     cost_q, cost_d, ref_cost;
  logic [2*MVL-1:0] mv_q, mv_d;

  always_comb begin
    ref_cost = clr_i ? '1 : cost_q;
    cost_d   = ref_cost;
    mv_d     = clr_i ? '0 : mv_q;
    // Strict compare: ties keep the earlier MV and an all-ones cost is never captured.
    if (vld_i && (cost_i < ref_cost)) begin
      cost_d = cost_i;
      mv_d   = mv_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cost_q <= '0;
      mv_q   <= '0;
    end else begin
      cost_q <= cost_d;
      mv_q   <= mv_d;
    end
  end

  assign best_cost_o = cost_q;
  assign best_mv_o   = mv_q;

endmodule

// File: rtl/ime_best_costx16.sv
// Tracks best cost/MV for the five large partitions over an MB search window, then picks
// the MB partition mode (16x16/16x8/8x16) one cycle after the last candidate.
module ime_best_costx16
  import ime_best_costx16_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  ime_best_costx16_if.slave bus
);

  localparam int L8  = SAD8X16_LEN;
  localparam int L16 = SAD16X16_LEN;
  localparam int MVL = MV_LEN;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mb_part_q, mb_part_d;
  logic             cand_v;
  logic [2*MVL-1:0] cand_mv;
  logic [2*L8-1:0]  bc8x16, bc16x8;
  logic [L16-1:0]   bc16x16;
  logic [4*MVL-1:0] bmv8x16, bmv16x8;
  logic [2*MVL-1:0] bmv16x16;
  logic [L16-1:0]   s168, s816;

  // A candidate on the start cycle belongs to the new window, whatever state we were in.
  assign cand_v  = bus.cost_v_i & (bus.start_i | (state_q == ST_SEARCH));
  assign cand_mv = {bus.mv_y_i, bus.mv_x_i};

  for (genvar g = 0; g < SAD8X16_NUM; g++) begin : g_8x16
    ime_min_tracker #(.W(L8), .MVL(MVL)) u_trk (
      .clk         (clk),
      .rstn        (rstn),
      .clr_i       (bus.start_i),
      .vld_i       (cand_v),
      .cost_i      (bus.cost8x16_i[g*L8 +: L8]),
      .mv_i        (cand_mv),
      .best_cost_o (bc8x16[g*L8 +: L8]),
      .best_mv_o   (bmv8x16[g*2*MVL +: 2*MVL])
    );
  end

  for (genvar g = 0; g < SAD16X8_NUM; g++) begin : g_16x8
    ime_min_tracker #(.W(L8), .MVL(MVL)) u_trk (
      .clk         (clk),
      .rstn        (rstn),
      .clr_i       (bus.start_i),
      .vld_i       (cand_v),
      .cost_i      (bus.cost16x8_i[g*L8 +: L8]),
      .mv_i        (cand_mv),
      .best_cost_o (bc16x8[g*L8 +: L8]),
      .best_mv_o   (bmv16x8[g*2*MVL +: 2*MVL])
    );
  end

  ime_min_tracker #(.W(L16), .MVL(MVL)) u_trk_16x16 (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (bus.start_i),
    .vld_i       (cand_v),
    .cost_i      (bus.cost16x16_i),
    .mv_i        (cand_mv),
    .best_cost_o (bc16x16),
    .best_mv_o   (bmv16x16)
  );

  // Two L8 costs summed into L8+1 bits cannot overflow.
  assign s168 = {1'b0, bc16x8[L8-1:0]} + {1'b0, bc16x8[2*L8-1:L8]};
  assign s816 = {1'b0, bc8x16[L8-1:0]} + {1'b0, bc8x16[2*L8-1:L8]};

  always_comb begin
    state_d   = state_q;
    mb_part_d = mb_part_q;
    if (bus.start_i) begin
      state_d = ST_SEARCH;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_SEARCH: if (bus.cost_v_i && bus.last_i) state_d = ST_DECIDE;
        ST_DECIDE: begin
          state_d   = ST_DONE;
          mb_part_d = pick_mb_part(bc16x16, s168, s816);
        end
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      mb_part_q <= MB_PART_16X16;
    end else begin
      state_q   <= state_d;
      mb_part_q <= mb_part_d;
    end
  end

  assign bus.busy_o       = (state_q == ST_SEARCH) | (state_q == ST_DECIDE);
  assign bus.done_o       = (state_q == ST_DONE);
  assign bus.mb_part_o    = mb_part_q;
  assign bus.bcost8x16_o  = bc8x16;
  assign bus.bcost16x8_o  = bc16x8;
  assign bus.bcost16x16_o = bc16x16;
  assign bus.bmv8x16_o    = bmv8x16;
  assign bus.bmv16x8_o    = bmv16x8;
  assign bus.bmv16x16_o   = bmv16x16;
  assign bus.dbg_state_o  = state_q;

endmodule

// File: tb/tb_ime_best_costx16.sv
// Directed bench for ime_best_costx16: hand-computed per-partition minima, mode decisions,
// restart, noise rejection, async reset and maximum-width sums.
module tb_ime_best_costx16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  ime_best_costx16_if bus ();

  ime_best_costx16 dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

  function automatic logic [13:0] mv2(input int x, input int y);
    return {y[6:0], x[6:0]};
  endfunction

  // Costs concatenated as {16x16, 16x8[1], 16x8[0], 8x16[1], 8x16[0]}.
  function automatic logic [75:0] cc(input int c16, input int a0, input int a1,
                                     input int b0, input int b1);
    return {c16[15:0], a1[14:0], a0[14:0], b1[14:0], b0[14:0]};
  endfunction

  task automatic set_in(input logic st, input logic v, input logic lst, input int mx, input int my,
                        input int c16, input int a0, input int a1, input int b0, input int b1);
    @(negedge clk);
    bus.start_i     = st;
    bus.cost_v_i    = v;
    bus.last_i      = lst;
    bus.mv_x_i      = mx[6:0];
    bus.mv_y_i      = my[6:0];
    bus.cost16x16_i = c16[15:0];
    bus.cost16x8_i  = {a1[14:0], a0[14:0]};
    bus.cost8x16_i  = {b1[14:0], b0[14:0]};
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Start, one candidate with last, then stop on the negedge of the DONE cycle.
  task automatic run_one(input int mx, input int my, input int c16,
                         input int a0, input int a1, input int b0, input int b1);
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 1'b1, mx, my, c16, a0, a1, b0, b1);
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    n_total++; if ({bus.busy_o, bus.done_o, bus.mb_part_o, bus.dbg_state_o} !== 6'd0)
      $display("FAIL reset_ctrl: got %b want 000000", {bus.busy_o, bus.done_o, bus.mb_part_o, bus.dbg_state_o}); else n_pass++;
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== 76'd0)
      $display("FAIL reset_bcost: got %h want 0", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}); else n_pass++;
    n_total++; if ({bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o} !== 70'd0)
      $display("FAIL reset_bmv: got %h want 0", {bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o}); else n_pass++;
    rstn = 1'b1;
    idle();
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 1'b1, 3, -2, 100, 60, 50, 70, 70);
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== {76{1'b1}} || bus.busy_o !== 1'b1)
      $display("FAIL single_clear: got %h busy %b want all-ones busy 1", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, bus.busy_o); else n_pass++;
    idle();
    n_total++; if (bus.done_o !== 1'b0 || bus.dbg_state_o !== 2'd2)
      $display("FAIL single_n1: got done %b state %0d want 0 2", bus.done_o, bus.dbg_state_o); else n_pass++;
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== cc(100, 60, 50, 70, 70))
      $display("FAIL single_bcost: got %h want %h", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, cc(100, 60, 50, 70, 70)); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd0)
      $display("FAIL single_done: got done %b part %0d want 1 0", bus.done_o, bus.mb_part_o); else n_pass++;
    n_total++; if ({bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o} !== {5{mv2(3, -2)}})
      $display("FAIL single_bmv: got %h want %h", {bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o}, {5{mv2(3, -2)}}); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.bcost16x16_o !== 16'd100 || done_cnt - d0 !== 1)
      $display("FAIL single_hold: got done %b busy %b c16 %0d pulses %0d want 0 0 100 1", bus.done_o, bus.busy_o, bus.bcost16x16_o, done_cnt - d0); else n_pass++;
  endtask

  task automatic test_per_partition();
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 1'b0, 1, 1, 500, 300, 300, 400, 100);
    set_in(1'b0, 1'b1, 1'b0, 2, 2, 400, 200, 350, 400, 90);
    set_in(1'b0, 1'b1, 1'b0, -3, 4, 450, 250, 100, 50, 95);
    set_in(1'b0, 1'b1, 1'b1, 5, -5, 400, 199, 120, 60, 200);
    idle();
    @(negedge clk);
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== cc(400, 199, 100, 50, 90))
      $display("FAIL part_bcost: got %h want %h", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, cc(400, 199, 100, 50, 90)); else n_pass++;
    n_total++; if (bus.bmv16x16_o !== mv2(2, 2))
      $display("FAIL part_tie_mv: got %h want %h", bus.bmv16x16_o, mv2(2, 2)); else n_pass++;
    n_total++; if ({bus.bmv16x8_o, bus.bmv8x16_o} !== {mv2(-3, 4), mv2(5, -5), mv2(2, 2), mv2(-3, 4)})
      $display("FAIL part_bmv: got %h want %h", {bus.bmv16x8_o, bus.bmv8x16_o}, {mv2(-3, 4), mv2(5, -5), mv2(2, 2), mv2(-3, 4)}); else n_pass++;
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd2)
      $display("FAIL part_mode: got done %b part %0d want 1 2", bus.done_o, bus.mb_part_o); else n_pass++;
  endtask

  task automatic test_mode_ties();
    run_one(0, 0, 200, 100, 100, 150, 50);
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd0)
      $display("FAIL tie_all: got done %b part %0d want 1 0", bus.done_o, bus.mb_part_o); else n_pass++;
    run_one(0, 0, 201, 100, 100, 150, 50);
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd1)
      $display("FAIL tie_168: got done %b part %0d want 1 1", bus.done_o, bus.mb_part_o); else n_pass++;
    run_one(0, 0, 300, 150, 100, 100, 99);
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd2)
      $display("FAIL tie_816: got done %b part %0d want 1 2", bus.done_o, bus.mb_part_o); else n_pass++;
    idle();
  endtask

  task automatic test_restart();
    int d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) set_in(1'b0, 1'b1, 1'b0, 1, 1, 10 + i, 10, 11, 12, 13);
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 1'b1, -7, 6, 1000, 900, 800, 700, 600);
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== {76{1'b1}} || bus.dbg_state_o !== 2'd1)
      $display("FAIL restart_clear: got %h state %0d want all-ones 1", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, bus.dbg_state_o); else n_pass++;
    idle();
    @(negedge clk);
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== cc(1000, 900, 800, 700, 600) || bus.mb_part_o !== 2'd0)
      $display("FAIL restart_res: got %h part %0d want %h 0", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, bus.mb_part_o, cc(1000, 900, 800, 700, 600)); else n_pass++;
    n_total++; if ({bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o} !== {5{mv2(-7, 6)}})
      $display("FAIL restart_bmv: got %h want %h", {bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o}, {5{mv2(-7, 6)}}); else n_pass++;
    idle();
    n_total++; if (done_cnt - d0 !== 1)
      $display("FAIL restart_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_noise();
    int d0 = done_cnt;
    set_in(1'b0, 1'b1, 1'b1, 9, 9, 5, 5, 5, 5, 5);
    idle();
    n_total++; if (bus.dbg_state_o !== 2'd0 || bus.busy_o !== 1'b0 || {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== cc(1000, 900, 800, 700, 600))
      $display("FAIL noise_idle: got state %0d busy %b bcost %h want 0 0 %h", bus.dbg_state_o, bus.busy_o, {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, cc(1000, 900, 800, 700, 600)); else n_pass++;
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) set_in(1'b0, 1'b0, 1'b1, 9, 9, 5, 5, 5, 5, 5);
    set_in(1'b0, 1'b1, 1'b1, 2, -1, 300, 100, 100, 120, 120);
    n_total++; if (bus.dbg_state_o !== 2'd1 || bus.done_o !== 1'b0 || bus.bcost16x16_o !== 16'hFFFF)
      $display("FAIL noise_last: got state %0d done %b c16 %h want 1 0 ffff", bus.dbg_state_o, bus.done_o, bus.bcost16x16_o); else n_pass++;
    idle();
    set_in(1'b0, 1'b1, 1'b1, 9, 9, 5, 5, 5, 5, 5);
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd1)
      $display("FAIL noise_done: got done %b part %0d want 1 1", bus.done_o, bus.mb_part_o); else n_pass++;
    idle();
    n_total++; if (bus.dbg_state_o !== 2'd0 || {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== cc(300, 100, 100, 120, 120) || bus.mb_part_o !== 2'd1)
      $display("FAIL noise_in_done: got state %0d bcost %h part %0d want 0 %h 1", bus.dbg_state_o, {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, bus.mb_part_o, cc(300, 100, 100, 120, 120)); else n_pass++;
    idle();
    n_total++; if (done_cnt - d0 !== 1)
      $display("FAIL noise_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_max_width();
    set_in(1'b1, 1'b1, 1'b0, -64, 63, 65535, 32767, 32767, 32766, 32766);
    set_in(1'b0, 1'b1, 1'b1, 1, 1, 65535, 32767, 32767, 32767, 32767);
    idle();
    @(negedge clk);
    n_total++; if ({bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o} !== cc(65535, 32767, 32767, 32766, 32766))
      $display("FAIL max_bcost: got %h want %h", {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}, cc(65535, 32767, 32767, 32766, 32766)); else n_pass++;
    n_total++; if ({bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o} !== {42'd0, mv2(-64, 63), mv2(-64, 63)})
      $display("FAIL max_bmv: got %h want %h", {bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o}, {42'd0, mv2(-64, 63), mv2(-64, 63)}); else n_pass++;
    n_total++; if (bus.done_o !== 1'b1 || bus.mb_part_o !== 2'd2)
      $display("FAIL max_mode: got done %b part %0d want 1 2", bus.done_o, bus.mb_part_o); else n_pass++;
    idle();
  endtask

  task automatic test_async_reset();
    int d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 1'b0, 4, 4, 40, 40, 40, 40, 40);
    idle();
    #2 rstn = 1'b0;
    #1;
    n_total++; if ({bus.busy_o, bus.done_o, bus.mb_part_o, bus.dbg_state_o} !== 6'd0 || {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o, bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o} !== 146'd0)
      $display("FAIL arst_search: got ctrl %b bcost %h want 0 0", {bus.busy_o, bus.done_o, bus.mb_part_o, bus.dbg_state_o}, {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}); else n_pass++;
    @(negedge clk) rstn = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 1'b1, 4, 4, 300, 40, 40, 40, 40);
    @(posedge clk);
    #1;
    n_total++; if (bus.dbg_state_o !== 2'd2 || bus.busy_o !== 1'b1)
      $display("FAIL arst_pre: got state %0d busy %b want 2 1", bus.dbg_state_o, bus.busy_o); else n_pass++;
    rstn = 1'b0;
    #1;
    n_total++; if ({bus.busy_o, bus.done_o, bus.mb_part_o, bus.dbg_state_o} !== 6'd0 || {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o, bus.bmv16x16_o, bus.bmv16x8_o, bus.bmv8x16_o} !== 146'd0)
      $display("FAIL arst_decide: got ctrl %b bcost %h want 0 0", {bus.busy_o, bus.done_o, bus.mb_part_o, bus.dbg_state_o}, {bus.bcost16x16_o, bus.bcost16x8_o, bus.bcost8x16_o}); else n_pass++;
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    n_total++; if (done_cnt - d0 !== 0 || bus.dbg_state_o !== 2'd0)
      $display("FAIL arst_nodone: got pulses %0d state %0d want 0 0", done_cnt - d0, bus.dbg_state_o); else n_pass++;
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.cost_v_i    = 1'b0;
    bus.last_i      = 1'b0;
    bus.mv_x_i      = '0;
    bus.mv_y_i      = '0;
    bus.cost16x16_i = '0;
    bus.cost16x8_i  = '0;
    bus.cost8x16_i  = '0;
    test_reset();
    test_single();
    test_per_partition();
    test_mode_ties();
    test_restart();
    test_noise();
    test_max_width();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
